// File: rtl/regfile_mp_sb.sv
// Multi-port decode-stage register file with write-first bypass, optional hardwired-zero
// register and a per-register pending-write scoreboard. All outputs are registered.
module regfile_mp_sb #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter bit          ZERO_REG       = 1'b1,
    localparam int unsigned ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                write_enable,
    input  logic [ADDR_W-1:0]                   write_addr,
    input  logic [WORD_SIZE-1:0]                write_data,
    input  logic                                issue_enable,
    input  logic [ADDR_W-1:0]                   issue_addr,
    input  logic [NUM_READ_PORTS*ADDR_W-1:0]    read_addr,
    output logic [NUM_READ_PORTS*WORD_SIZE-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]           read_busy,
    output logic [NUM_REGS-1:0]                 busy_vector
);

    logic [WORD_SIZE-1:0]                regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0]                regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]                 busy_q, busy_d;
    logic [NUM_READ_PORTS*WORD_SIZE-1:0] rdata_q, rdata_d;
    logic [NUM_READ_PORTS-1:0]           rbusy_q, rbusy_d;
    logic                                wr_ok, iss_ok;

    // Out-of-range addresses and the hardwired zero register are never stored or tracked.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wr_ok  = write_enable && addr_valid(write_addr);
        iss_ok = issue_enable && addr_valid(issue_addr);
        if (wr_ok) begin
            regs_d[write_addr] = write_data;
            busy_d[write_addr] = 1'b0;
        end
        // Issue after writeback so a new producer supersedes the retiring one.
        if (iss_ok) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    // Reading the next-state arrays gives write-first data and a busy flag consistent with it.
    always_comb begin : read_ports
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rdata_d = '0;
        rbusy_d = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            ra = read_addr[p*ADDR_W +: ADDR_W];
            if (addr_valid(ra)) begin
                rdata_d[p*WORD_SIZE +: WORD_SIZE] = regs_d[ra];
                rbusy_d[p]                        = busy_d[ra];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            rdata_q <= '0;
            rbusy_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

    assign read_data   = rdata_q;
    assign read_busy   = rbusy_q;
    assign busy_vector = busy_q;

endmodule
